// File: rtl/slice_collector.sv
// slice_collector: sequences the text-file reader through NUM_FILES files, captures DEPTH words each,
// and presents each full buffer to the consumer. Optional XOR checksum enabled by SLICE_CHECKSUM_EN.
module slice_collector #(
    parameter int WORD_W    = 25,
    parameter int DEPTH     = 64,
    parameter int NUM_FILES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       file_load,
    output logic [9:0]                 file_index,
    output logic                       rd,
    input  logic [WORD_W-1:0]          rd_data,
    output logic                       buf_valid,
    input  logic [$clog2(DEPTH)-1:0]   buf_raddr,
    output logic [WORD_W-1:0]          buf_rdata,
    input  logic                       buf_release,
    output logic                       busy,
    output logic                       done,
    output logic [WORD_W-1:0]          checksum
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_RD   = CNT_W'(DEPTH - 1);
    localparam logic [9:0]       LAST_FILE = 10'(NUM_FILES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_READY = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  w_rd_cnt_nxt;
    logic [9:0]        r_file_index;
    logic [9:0]        w_file_index_nxt;
    logic              r_file_load;
    logic              r_rd;
    logic              r_rd_q;
    logic              r_buf_valid;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [WORD_W-1:0] r_buf [DEPTH];

    // Next-state, read counter and file index decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_rd_cnt_nxt     = r_rd_cnt;
        w_file_index_nxt = r_file_index;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt      = S_OPEN;
                    w_file_index_nxt = 10'd0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_OPEN: begin
                w_state_nxt  = S_READ;
                w_rd_cnt_nxt = '0;
            end
            S_READ: begin
                w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
                if (r_rd_cnt == LAST_RD) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_READY;
            end
            S_READY: begin
                if (buf_release && (r_file_index == LAST_FILE)) begin
                    w_state_nxt = S_DONE;
                end else if (buf_release) begin
                    w_state_nxt      = S_OPEN;
                    w_file_index_nxt = r_file_index + 10'd1;
                end else begin
                    w_state_nxt = S_READY;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rd_cnt     <= '0;
            r_file_index <= 10'd0;
            r_file_load  <= 1'b0;
            r_rd         <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_cnt     <= w_rd_cnt_nxt;
            r_file_index <= w_file_index_nxt;
            r_file_load  <= (w_state_nxt == S_OPEN);
            r_rd         <= (w_state_nxt == S_READ);
            r_buf_valid  <= (w_state_nxt == S_READY);
            r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    // Capture pipeline control: reader data arrives one cycle after the rd strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_q   <= 1'b0;
            r_wr_ptr <= '0;
        end else begin
            r_rd_q <= r_rd;
            if (r_state == S_OPEN) begin
                r_wr_ptr <= '0;
            end else if (r_rd_q) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
        end
    end

    // Buffer storage; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && r_rd_q) begin
            r_buf[r_wr_ptr] <= rd_data;
        end
    end

`ifdef SLICE_CHECKSUM_EN
    logic [WORD_W-1:0] r_checksum;

    // XOR of every captured word of the current file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (r_state == S_OPEN) begin
            r_checksum <= '0;
        end else if (r_rd_q) begin
            r_checksum <= r_checksum ^ rd_data;
        end else begin
            r_checksum <= r_checksum;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign file_load  = r_file_load;
    assign file_index = r_file_index;
    assign rd         = r_rd;
    assign buf_valid  = r_buf_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign buf_rdata  = r_buf_valid ? r_buf[buf_raddr] : '0;

endmodule

// File: doc/slice_collector.md
Name: slice_collector

Overview:
- Downstream consumer and sequencer for the text-file input reader.
- Drives the reader's load and read strobes and walks file indices 0..NUM_FILES-1.
- Captures DEPTH words of WORD_W bits per file into an internal buffer.
- Presents each completed buffer to the next compute stage over a random-access read port with a release handshake.

Parameters:
- WORD_W, 25, width of one data word (one slice).
- DEPTH, 64, words per input file; power of two; ADDR_W = log2(DEPTH).
- NUM_FILES, 4, number of files processed per start; 1..1024.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run at file index 0; sampled in IDLE or DONE only
- file_load  out  1  one-cycle pulse telling the reader to open file file_index
- file_index  out  10  current file number
- rd  out  1  read strobe to reader; data returns on rd_data one cycle later
- rd_data  in  WORD_W  word from reader
- buf_valid  out  1  buffer full and readable
- buf_raddr  in  ADDR_W  buffer read address
- buf_rdata  out  WORD_W  combinational buf[buf_raddr] when buf_valid=1, else 0
- buf_release  in  1  consumer done with buffer; honoured only while buf_valid=1
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- checksum  out  WORD_W  see Optional Feature

Behaviour:
- **Reset:**
  - On rst=1 at a clock edge: state goes to IDLE.
  - file_load, rd, buf_valid, busy, done become 0; file_index=0; checksum=0; rd_cnt=0; wr_ptr=0; rd_q=0.
  - Buffer array is not cleared; buf_rdata reads 0 because buf_valid=0.
  - Reset mid-operation aborts immediately; rd drops on the same edge; no partial buffer is ever presented.
- **FSM states:**
  - IDLE: start → OPEN with file_index=0.
  - OPEN (1 cycle): file_load=1. Next state READ with rd_cnt=0 and wr_ptr=0.
  - READ: rd=1 every cycle for exactly DEPTH cycles, counted by rd_cnt. After the DEPTH-th rd cycle → DRAIN.
  - DRAIN (1 cycle): rd=0; captures the final word. → READY.
  - READY: buf_valid=1, busy=1. Waits indefinitely for buf_release.
    - If buf_release and file_index==NUM_FILES-1 → DONE.
    - If buf_release otherwise → OPEN with file_index+1.
  - DONE: done=1, busy=0; holds until start (→ OPEN, file_index=0) or rst.
- **Capture pipeline:**
  - rd_q is rd registered.
  - On each edge with rd_q=1: buf[wr_ptr] ← rd_data; wr_ptr increments and wraps modulo DEPTH.
  - First word lands at address 0; word k lands at address k.
- **Latency:** OPEN to READY is DEPTH+2 cycles (1 READ entry + DEPTH reads + 1 drain, counting from the edge leaving OPEN).
- **Boundary conditions:**
  - start while busy: ignored.
  - buf_release outside READY: ignored.
  - buf_release held high: consumes only one buffer, because buf_valid=0 in OPEN.
  - NUM_FILES=1: READY → DONE directly.
  - file_index never exceeds NUM_FILES-1.
  - buf_raddr may change every cycle; no read latency.

Optional Feature:
- Macro: SLICE_CHECKSUM_EN.
- When defined:
  - checksum is a WORD_W register cleared in OPEN.
  - XOR-accumulates every captured word (same edge as the buffer write).
  - Stable and meaningful while buf_valid=1.
- When undefined:
  - checksum is constant 0.
  - No accumulator logic is synthesised.
- Port list is identical in both builds.

Test Plan:
- **Reset/idle:** rst high 3 cycles, start=0 → all outputs 0, file_index=0, no rd or file_load for 20 cycles.
- **Single file, DEPTH=64, NUM_FILES=1:**
  - Stimulus: reader model returns word k = k*3+1; pulse start.
  - Expected: file_load high exactly 1 cycle; rd high exactly 64 consecutive cycles; buf_valid rises 66 cycles after OPEN.
  - Expected: buf_raddr=0 reads 1; buf_raddr=63 reads 190.
  - Expected: buf_release → done=1, busy=0.
- **Four files:**
  - Stimulus: reader model returns {file_index[4:0], 20'(k)}; release each buffer after 10 cycles.
  - Expected: file_index steps 0,1,2,3; buf[5] of file 2 = {5'd2, 20'd5}; done after 4th release.
- **Handshake robustness:**
  - Stimulus: hold buf_release=1 continuously from start.
  - Expected: each buffer is still presented for ≥1 cycle with buf_valid=1; exactly NUM_FILES file_load pulses.
- **Reset mid-READ:**
  - Stimulus: assert rst at rd_cnt=30.
  - Expected: next cycle rd=0, busy=0, buf_valid=0.
  - Then start again: a fresh run from file_index=0 completes correctly with word 0 at address 0.
- **Checksum (SLICE_CHECKSUM_EN defined):**
  - Stimulus: words k=0..63, each equal to k.
  - Expected: checksum = XOR(0..63) = 0 in READY.
  - Stimulus: words all 25'h1FFFFFF.
  - Expected: checksum = 0 (even count).
  - Stimulus: word 7 = 25'h0000155, others 0.
  - Expected: checksum = 25'h0000155.
  - Undefined build: checksum stays 0.
